// File: rtl/div_unit_if.sv
// Divider request/result bundle between the EX stage and the multi-cycle divider.
// The master is the EX stage; the slave is the divider.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, op, operand_a, operand_b,
    input  stall, result_valid, result
  );

  modport slave (
    input  start, kill, op, operand_a, operand_b,
    output stall, result_valid, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Normal latency XLEN+1 cycles to result_valid, 1 cycle for divide-by-zero/overflow; stalls upstream meanwhile.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  dif
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [1:0]      op_q;
  logic            neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] result_q;
  logic            result_valid_q;

  logic            signed_op, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin;

  assign signed_op = ~dif.op[0];
  assign a_neg     = signed_op & dif.operand_a[XLEN-1];
  assign b_neg     = signed_op & dif.operand_b[XLEN-1];
  assign abs_a     = a_neg ? (~dif.operand_a + 1'b1) : dif.operand_a;
  assign abs_b     = b_neg ? (~dif.operand_b + 1'b1) : dif.operand_b;
  assign div_zero  = (dif.operand_b == '0);
  assign ovf       = signed_op && (dif.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (dif.operand_b == '1);

  // Divide-by-zero and overflow results bypass the iteration entirely.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = dif.op[1] ? dif.operand_a : '1;
    else
      special_res = dif.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Shift in the next dividend bit and trial-subtract; a clear borrow commits.
  assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

  always_comb begin
    if (!trial[XLEN]) begin
      rem_nxt = trial[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign q_fin = neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt;
  assign r_fin = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;

  assign dif.stall        = !dif.kill && (((state_q == IDLE) && dif.start) || (state_q == CALC));
  assign dif.result_valid = result_valid_q;
  assign dif.result       = result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      dvs_q          <= '0;
      op_q           <= '0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (dif.kill) begin
      state_q        <= IDLE;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          result_valid_q <= 1'b0;
          if (dif.start) begin
            op_q      <= dif.op;
            quo_q     <= abs_a;
            rem_q     <= '0;
            dvs_q     <= abs_b;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (div_zero || ovf) begin
              state_q        <= DONE;
              result_q       <= special_res;
              result_valid_q <= 1'b1;
            end else begin
              state_q <= CALC;
              cnt_q   <= CW'(XLEN-1);
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt_q == '0) begin
            state_q        <= DONE;
            result_q       <= op_q[1] ? r_fin : q_fin;
            result_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q        <= IDLE;
          result_valid_q <= 1'b0;
        end
        default: begin
          state_q        <= IDLE;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed checks of div_unit against an arithmetic reference model.
module tb_div_unit;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  div_unit_if #(.XLEN(32)) dif();

  div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == MIN_INT) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN_INT : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || (!o[0] && a == MIN_INT && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic scramble();
    dif.op        = 2'($urandom);
    dif.operand_a = $urandom;
    dif.operand_b = $urandom;
  endtask

  // Launch one divide in cycle 0, then watch stall/result_valid for a fixed window.
  task automatic do_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int stall_cnt = 0;
    int rv_cnt    = 0;
    int rv_cyc    = -1;
    logic [31:0] res = '0;
    @(posedge clk); #1;
    dif.start = 1'b1; dif.op = o; dif.operand_a = a; dif.operand_b = b;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (dif.stall) stall_cnt++;
      if (dif.result_valid) begin rv_cnt++; rv_cyc = c; res = dif.result; end
      @(posedge clk); #1;
      dif.start = 1'b0;
      scramble();
    end
    chk({tag, " stall_cycles"}, stall_cnt, exp_lat);
    chk({tag, " rv_count"}, rv_cnt, 1);
    chk({tag, " rv_cycle"}, rv_cyc, exp_lat);
    chk({tag, " result"}, res, exp_res);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, r;
    int          lat;
  } vec_t;

  vec_t dir[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.start = 1'b0; dif.kill = 1'b0; dif.op = 2'b00;
    dif.operand_a = '0; dif.operand_b = '0;
    dir[0] = '{2'b00, 32'd100, 32'd7, 32'd14, 33};
    dir[1] = '{2'b10, 32'd100, 32'd7, 32'd2, 33};
    dir[2] = '{2'b00, -32'sd100, 32'd7, 32'hFFFF_FFF2, 33};
    dir[3] = '{2'b10, -32'sd100, 32'd7, 32'hFFFF_FFFE, 33};
    dir[4] = '{2'b11, 32'hFFFF_FFFF, 32'd2, 32'd1, 33};
    dir[5] = '{2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33};
    dir[6] = '{2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    dir[7] = '{2'b11, 32'd5, 32'd0, 32'd5, 1};
    dir[8] = '{2'b00, MIN_INT, 32'hFFFF_FFFF, MIN_INT, 1};
    dir[9] = '{2'b10, MIN_INT, 32'hFFFF_FFFF, 32'd0, 1};

    #3;
    chk("reset stall", {31'b0, dif.stall}, 32'd0);
    chk("reset rv", {31'b0, dif.result_valid}, 32'd0);
    chk("reset result", dif.result, 32'd0);
    rst = 1'b0;
    #3;
    dif.start = 1'b1; #1;
    chk("idle comb stall", {31'b0, dif.stall}, 32'd1);
    dif.start = 1'b0;

    foreach (dir[i]) begin
      chk($sformatf("model dir%0d", i), ref_div(dir[i].o, dir[i].a, dir[i].b), dir[i].r);
      do_div($sformatf("dir%0d", i), dir[i].o, dir[i].a, dir[i].b, dir[i].r, dir[i].lat);
    end

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      int sel;
      o   = 2'($urandom);
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1:       begin a = MIN_INT; b = 32'hFFFF_FFFF; end
        2, 3:    b = $urandom_range(1, 20);
        4:       b = -$urandom_range(1, 20);
        5:       begin a = $urandom_range(0, 1000); b = $urandom; end
        default: b = $urandom;
      endcase
      do_div($sformatf("rnd%0d", i), o, a, b, ref_div(o, a, b), ref_lat(o, a, b));
    end

    // Back-to-back: start held through both launches, operands churn in between.
    begin
      logic [31:0] res[2];
      int rv_cyc[2];
      int rv_cnt = 0;
      @(posedge clk); #1;
      dif.start = 1'b1; dif.op = 2'b00; dif.operand_a = 32'd1000; dif.operand_b = 32'd9;
      for (int c = 0; c < 90; c++) begin
        @(negedge clk);
        if (dif.result_valid) begin
          if (rv_cnt < 2) begin res[rv_cnt] = dif.result; rv_cyc[rv_cnt] = c; end
          rv_cnt++;
        end
        @(posedge clk); #1;
        scramble();
        if (c == 33) begin
          dif.op = 2'b11; dif.operand_a = 32'd12345; dif.operand_b = 32'd100;
        end
        if (c >= 34) dif.start = 1'b0;
      end
      chk("b2b rv_count", rv_cnt, 2);
      chk("b2b first_cycle", rv_cyc[0], 33);
      chk("b2b spacing", rv_cyc[1] - rv_cyc[0], 34);
      chk("b2b res0", res[0], ref_div(2'b00, 32'd1000, 32'd9));
      chk("b2b res1", res[1], ref_div(2'b11, 32'd12345, 32'd100));
    end

    // Kill at CALC cycle 10.
    begin
      int rv_cnt = 0;
      @(posedge clk); #1;
      dif.start = 1'b1; dif.op = 2'b01; dif.operand_a = 32'hDEAD_BEEF; dif.operand_b = 32'd3;
      for (int c = 0; c < 45; c++) begin
        @(negedge clk);
        if (c == 10) chk("kill stall", {31'b0, dif.stall}, 32'd0);
        if (dif.result_valid) rv_cnt++;
        @(posedge clk); #1;
        dif.start = 1'b0;
        dif.kill  = (c == 9);
      end
      chk("kill rv_count", rv_cnt, 0);
      do_div("post_kill", 2'b01, 32'd9, 32'd3, 32'd3, 33);
    end

    // Asynchronous reset mid-CALC.
    begin
      int rv_cnt = 0;
      @(posedge clk); #1;
      dif.start = 1'b1; dif.op = 2'b00; dif.operand_a = 32'd77777; dif.operand_b = 32'd5;
      @(posedge clk); #1;
      dif.start = 1'b0;
      repeat (12) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst stall", {31'b0, dif.stall}, 32'd0);
      chk("arst rv", {31'b0, dif.result_valid}, 32'd0);
      chk("arst result", dif.result, 32'd0);
      #1 rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (dif.result_valid) rv_cnt++;
      end
      chk("arst rv_count", rv_cnt, 0);
      do_div("post_rst", 2'b10, -32'sd77, 32'd10, 32'hFFFF_FFF9, 33);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
